// File: rtl/eth_buf_pkg.sv
// Shared definitions for the Ethernet store-and-forward frame buffer.
//   LEN_W_DEF   default width of a frame-length field
//   MAX_FRM_DEF default longest accepted frame, in entries
//   frm_len_t   frame-length type at the default width
//   wr_state_t  write-side frame FSM states
package eth_buf_pkg;

    localparam int LEN_W_DEF   = 16;
    localparam int MAX_FRM_DEF = 1518;

    typedef logic [LEN_W_DEF-1:0] frm_len_t;

    typedef enum logic [1:0] {
        W_IDLE    = 2'd0,   // between frames
        W_FRAME   = 2'd1,   // storing bytes of the current frame
        W_DISCARD = 2'd2    // current frame already dropped, swallowing the rest
    } wr_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock first-word-fall-through FIFO, used as the per-frame length queue.
//   clk, rst_n  clock, async active-low reset (pointers only)
//   push, din   write strobe and data; ignored while full
//   pop         consume head entry; ignored while empty
//   dout        head entry, valid whenever !empty
//   full, empty occupancy flags
module sync_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);
    typedef logic [AW:0] ptr_t;

    logic [WIDTH-1:0] mem [DEPTH];
    ptr_t             wptr;
    ptr_t             rptr;

    // The extra MSB separates "same slot, empty" from "same slot, wrapped once".
    assign empty = (wptr == rptr);
    assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign dout  = mem[rptr[AW-1:0]];

    // NOTE: storage arrays get no reset; only the pointers define what is valid,
    // and leaving the array unreset lets it map onto RAM primitives.
    always_ff @(posedge clk) begin
        if (push && !full) mem[wptr[AW-1:0]] <= din;
    end

    // NOTE: state registers use non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (push && !full) wptr <= wptr + ptr_t'(1);
            if (pop && !empty) rptr <= rptr + ptr_t'(1);
        end
    end

endmodule

// File: rtl/frame_fifo.sv
// Store-and-forward frame buffer between MAC RX and TX control.
//   clk, rst_n               single clock, async active-low reset
//   wr_valid/wr_data         incoming byte stream
//   wr_last/wr_err           end-of-frame marker and bad-frame flag (taken with the last byte)
//   rd_ready                 consumer pops the head byte
//   rd_valid/rd_data/rd_last head byte of the oldest committed frame (FWFT)
//   rd_len                   length of that frame, 0 when nothing is committed
//   almost_full/full         registered occupancy flags for pause generation
//   drop_cnt                 saturating count of dropped frames
// Bytes of an in-progress frame sit between commit_ptr and wr_ptr; the read
// side only ever walks up to commit_ptr, so dropping a frame is just a rewind
// of wr_ptr.
module frame_fifo
    import eth_buf_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int DEPTH     = 2048,
    parameter int LEN_DEPTH = 32,
    parameter int LEN_W     = LEN_W_DEF,
    parameter int MAX_FRM   = MAX_FRM_DEF,
    parameter int AF_MARGIN = 256
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_valid,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              wr_last,
    input  logic              wr_err,
    input  logic              rd_ready,
    output logic              rd_valid,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_last,
    output logic [LEN_W-1:0]  rd_len,
    output logic              almost_full,
    output logic              full,
    output logic [15:0]       drop_cnt
);

    localparam int AW = $clog2(DEPTH);
    typedef logic [AW:0]      ptr_t;
    typedef logic [LEN_W-1:0] len_t;

    logic [DATA_W-1:0] mem [DEPTH];

    ptr_t      wr_ptr, wr_ptr_nxt;
    ptr_t      commit_ptr, commit_ptr_nxt;
    ptr_t      rd_ptr, rd_ptr_nxt;
    ptr_t      occ, occ_nxt, free_nxt;
    wr_state_t state, state_nxt;
    len_t      frm_cnt, frm_cnt_nxt, cnt_inc;
    len_t      rd_cnt, len_head;
    logic      store_full, mem_we, len_push, len_pop, len_full, len_empty;
    logic      drop, rd_fire;

    // ---------------- length queue ----------------
    sync_fifo #(.WIDTH(LEN_W), .DEPTH(LEN_DEPTH)) u_len_q (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (len_push),
        .din   (cnt_inc),
        .pop   (len_pop),
        .dout  (len_head),
        .full  (len_full),
        .empty (len_empty)
    );

    // ---------------- read side ----------------
    assign rd_valid = !len_empty;
    assign rd_len   = rd_valid ? len_head : '0;
    // rd_cnt counts bytes already taken from the head frame.
    assign rd_last  = rd_valid && (rd_cnt == len_head - len_t'(1));
    assign rd_data  = mem[rd_ptr[AW-1:0]];
    assign rd_fire  = rd_valid && rd_ready;
    assign len_pop  = rd_fire && rd_last;

    // ---------------- write side ----------------
    assign occ        = wr_ptr - rd_ptr;
    assign store_full = (occ == ptr_t'(DEPTH));
    assign cnt_inc    = (state == W_FRAME) ? frm_cnt + len_t'(1) : len_t'(1);

    // NOTE: every output of this block gets a default first, so no path
    // leaves a signal unassigned and no latch is inferred.
    always_comb begin
        state_nxt      = state;
        wr_ptr_nxt     = wr_ptr;
        commit_ptr_nxt = commit_ptr;
        frm_cnt_nxt    = frm_cnt;
        mem_we         = 1'b0;
        len_push       = 1'b0;
        drop           = 1'b0;
        if (wr_valid) begin
            unique case (state)
                W_IDLE, W_FRAME: begin
                    if (store_full || cnt_inc > len_t'(MAX_FRM)) begin
                        // Byte cannot be kept: abandon the whole frame.
                        drop       = 1'b1;
                        wr_ptr_nxt = commit_ptr;
                        state_nxt  = wr_last ? W_IDLE : W_DISCARD;
                    end else begin
                        mem_we      = 1'b1;
                        wr_ptr_nxt  = wr_ptr + ptr_t'(1);
                        frm_cnt_nxt = cnt_inc;
                        state_nxt   = W_FRAME;
                        if (wr_last) begin
                            state_nxt = W_IDLE;
                            if (!wr_err && !len_full) begin
                                commit_ptr_nxt = wr_ptr + ptr_t'(1);
                                len_push       = 1'b1;
                            end else begin
                                drop       = 1'b1;
                                wr_ptr_nxt = commit_ptr;
                            end
                        end
                    end
                end
                W_DISCARD: if (wr_last) state_nxt = W_IDLE;
                default:   state_nxt = W_IDLE;
            endcase
        end
    end

    // Flags are registered from the pointers as they will be after this edge.
    assign rd_ptr_nxt = rd_ptr + ptr_t'(rd_fire);
    assign occ_nxt    = wr_ptr_nxt - rd_ptr_nxt;
    assign free_nxt   = ptr_t'(DEPTH) - occ_nxt;

    always_ff @(posedge clk) begin
        if (mem_we) mem[wr_ptr[AW-1:0]] <= wr_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= W_IDLE;
            wr_ptr      <= '0;
            commit_ptr  <= '0;
            rd_ptr      <= '0;
            frm_cnt     <= '0;
            rd_cnt      <= '0;
            full        <= 1'b0;
            almost_full <= 1'b0;
            drop_cnt    <= '0;
        end else begin
            state       <= state_nxt;
            wr_ptr      <= wr_ptr_nxt;
            commit_ptr  <= commit_ptr_nxt;
            rd_ptr      <= rd_ptr_nxt;
            frm_cnt     <= frm_cnt_nxt;
            full        <= (occ_nxt == ptr_t'(DEPTH));
            almost_full <= (free_nxt <= ptr_t'(AF_MARGIN));
            if (len_pop)      rd_cnt <= '0;
            else if (rd_fire) rd_cnt <= rd_cnt + len_t'(1);
            if (drop && drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_frame_fifo.sv
// Self-checking bench for frame_fifo: a queue-based frame model tracks
// committed frames, the frame being written and the drop count, and is
// compared with the DUT on every falling clock edge.
module tb_frame_fifo;

    localparam int DATA_W    = 8;
    localparam int DEPTH     = 256;
    localparam int LEN_DEPTH = 8;
    localparam int LEN_W     = 16;
    localparam int MAX_FRM   = 100;
    localparam int AF_MARGIN = 32;

    logic              clk      = 1'b0;
    logic              rst_n    = 1'b0;
    logic              wr_valid = 1'b0;
    logic [DATA_W-1:0] wr_data  = '0;
    logic              wr_last  = 1'b0;
    logic              wr_err   = 1'b0;
    logic              rd_ready = 1'b0;
    logic              rd_valid;
    logic [DATA_W-1:0] rd_data;
    logic              rd_last;
    logic [LEN_W-1:0]  rd_len;
    logic              almost_full;
    logic              full;
    logic [15:0]       drop_cnt;

    always #5 clk = ~clk;

    frame_fifo #(
        .DATA_W(DATA_W), .DEPTH(DEPTH), .LEN_DEPTH(LEN_DEPTH),
        .LEN_W(LEN_W), .MAX_FRM(MAX_FRM), .AF_MARGIN(AF_MARGIN)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .wr_valid(wr_valid), .wr_data(wr_data), .wr_last(wr_last), .wr_err(wr_err),
        .rd_ready(rd_ready), .rd_valid(rd_valid), .rd_data(rd_data), .rd_last(rd_last),
        .rd_len(rd_len), .almost_full(almost_full), .full(full), .drop_cnt(drop_cnt)
    );

    int n_vec = 0;
    int n_bad = 0;
    int rd_mode = 0;   // 0: never ready, 1: always ready, 2: random

    // Model: committed unread bytes, committed frame lengths, pending frame.
    logic [7:0] m_data[$];
    int         m_lens[$];
    logic [7:0] m_pend[$];
    bit         m_disc;
    int         m_cons;
    int         m_drop;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        int occ;
        bit vld;
        bit lfull;
        if (!rst_n) begin
            m_data.delete(); m_lens.delete(); m_pend.delete();
            m_disc = 0; m_cons = 0; m_drop = 0;
        end
        occ = m_data.size() + m_pend.size();
        vld = (m_lens.size() != 0);
        check("rd_valid", 32'(rd_valid), 32'(vld));
        check("rd_len", 32'(rd_len), vld ? m_lens[0] : 0);
        check("rd_last", 32'(rd_last), 32'(vld && (m_cons + 1 == m_lens[0])));
        if (vld) check("rd_data", 32'(rd_data), 32'(m_data[0]));
        check("full", 32'(full), 32'(occ == DEPTH));
        check("almost_full", 32'(almost_full), 32'(DEPTH - occ <= AF_MARGIN));
        check("drop_cnt", 32'(drop_cnt), m_drop);
        if (rst_n) begin
            lfull = (m_lens.size() >= LEN_DEPTH);
            if (vld && rd_ready) begin
                void'(m_data.pop_front());
                m_cons++;
                if (m_cons == m_lens[0]) begin
                    void'(m_lens.pop_front());
                    m_cons = 0;
                end
            end
            if (wr_valid) begin
                if (m_disc) begin
                    if (wr_last) m_disc = 0;
                end else if (occ == DEPTH || m_pend.size() >= MAX_FRM) begin
                    m_drop = (m_drop < 65535) ? m_drop + 1 : m_drop;
                    m_pend.delete();
                    m_disc = !wr_last;
                end else begin
                    m_pend.push_back(wr_data);
                    if (wr_last) begin
                        if (!wr_err && !lfull) begin
                            m_lens.push_back(m_pend.size());
                            foreach (m_pend[i]) m_data.push_back(m_pend[i]);
                        end else begin
                            m_drop = (m_drop < 65535) ? m_drop + 1 : m_drop;
                        end
                        m_pend.delete();
                    end
                end
            end
        end
    end

    initial forever begin
        @(posedge clk); #1;
        case (rd_mode)
            0:       rd_ready = 1'b0;
            1:       rd_ready = 1'b1;
            default: rd_ready = 1'($urandom_range(1));
        endcase
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic idle_cycle();
        wr_valid = 1'b0; wr_last = 1'b0; wr_err = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic send_frame(input int len, input bit err, input bit gaps);
        for (int i = 0; i < len; i++) begin
            if (gaps) while ($urandom_range(3) == 0) idle_cycle();
            wr_valid = 1'b1;
            wr_data  = 8'($urandom);
            wr_last  = (i == len - 1);
            // wr_err only matters with the last byte; noise elsewhere must be ignored.
            wr_err   = (i == len - 1) ? err : 1'($urandom_range(1));
            @(posedge clk); #1;
        end
        wr_valid = 1'b0; wr_last = 1'b0; wr_err = 1'b0;
    endtask

    task automatic do_reset();
        wr_valid = 1'b0; wr_last = 1'b0; wr_err = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic drain();
        rd_mode = 1;
        for (int i = 0; i < 3000 && (m_lens.size() != 0 || rd_valid); i++) @(posedge clk);
        #1 check("drain_empty", 32'(rd_valid), 0);
    endtask

    initial begin
        // Reset values
        do_reset();
        check("rst_valid", 32'(rd_valid), 0);
        check("rst_len", 32'(rd_len), 0);
        check("rst_full", 32'(full), 0);
        check("rst_drop", 32'(drop_cnt), 0);

        // 64-byte frame, reader always ready
        rd_mode = 1;
        send_frame(64, 0, 0);
        check("t1_valid", 32'(rd_valid), 1);
        check("t1_len", 32'(rd_len), 64);
        drain();
        check("t1_drop", 32'(drop_cnt), 0);

        // Errored frame dropped, good frame kept
        do_reset();
        rd_mode = 0;
        send_frame(100, 1, 0);
        check("t2_drop", 32'(drop_cnt), 1);
        check("t2_novalid", 32'(rd_valid), 0);
        send_frame(60, 0, 0);
        check("t2_len", 32'(rd_len), 60);
        drain();
        check("t2_full", 32'(full), 0);
        check("t2_drop_end", 32'(drop_cnt), 1);

        // Exact fill, then frames arriving while full
        do_reset();
        rd_mode = 0;
        send_frame(90, 0, 0);
        send_frame(90, 0, 0);
        check("t3_af_lo", 32'(almost_full), 0);
        send_frame(76, 0, 0);
        check("t3_full", 32'(full), 1);
        check("t3_af_hi", 32'(almost_full), 1);
        send_frame(1, 0, 0);
        send_frame(10, 0, 0);
        check("t3_drop_full", 32'(drop_cnt), 2);
        drain();

        // Overflow mid-frame rewinds, no partial frame
        do_reset();
        rd_mode = 0;
        for (int k = 0; k < 3; k++) send_frame(90, 0, 0);
        check("t3_ovf_drop", 32'(drop_cnt), 1);
        check("t3_ovf_full", 32'(full), 0);
        drain();

        // Length queue full
        do_reset();
        rd_mode = 0;
        for (int k = 0; k < LEN_DEPTH + 1; k++) send_frame(2, 0, 0);
        check("t3_lenq_drop", 32'(drop_cnt), 1);
        drain();

        // Oversize frame, then single-byte and max-length frames
        do_reset();
        rd_mode = 1;
        send_frame(130, 0, 0);
        check("t4_drop", 32'(drop_cnt), 1);
        send_frame(1, 0, 0);
        check("t4_len1", 32'(rd_len), 1);
        check("t4_last1", 32'(rd_last), 1);
        send_frame(MAX_FRM, 0, 0);
        check("t4_lenmax", 32'(rd_len), MAX_FRM);
        drain();
        check("t4_drop_end", 32'(drop_cnt), 1);

        // Random traffic with random back-pressure
        do_reset();
        rd_mode = 2;
        for (int f = 0; f < 60; f++)
            send_frame($urandom_range(1, 110), ($urandom_range(7) == 0), 1);
        drain();

        // Back-to-back frames with concurrent reading: commit and pop coincide
        do_reset();
        rd_mode = 1;
        for (int f = 0; f < 12; f++) send_frame(64, 0, 0);
        check("t5_b2b_valid", 32'(rd_valid), 1);
        check("t5_b2b_drop", 32'(drop_cnt), 0);
        drain();

        // Async reset mid-frame while a frame is being read
        send_frame(5, 1, 0);
        rd_mode = 1;
        send_frame(64, 0, 0);
        for (int i = 0; i < 30; i++) begin
            wr_valid = 1'b1; wr_data = 8'($urandom); wr_last = 1'b0;
            @(posedge clk); #1;
        end
        #2 rst_n = 1'b0;
        #1;
        check("t6_valid", 32'(rd_valid), 0);
        check("t6_last", 32'(rd_last), 0);
        check("t6_len", 32'(rd_len), 0);
        check("t6_drop", 32'(drop_cnt), 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        wr_valid = 1'b0;
        send_frame(20, 0, 0);
        check("t6_len_after", 32'(rd_len), 20);
        drain();

        idle_cycle();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
